// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: stamps each retirement with rvfi_order, normalises
// the RVFI fields, and queues records for the monitor behind a valid/ready handshake.
module rvfi_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ret_valid_i,
  input  logic [31:0]      ret_insn_i,
  input  logic             ret_trap_i,
  input  logic             ret_halt_i,
  input  logic             ret_intr_i,
  input  logic [1:0]       ret_mode_i,
  input  logic [4:0]       ret_rs1_addr_i,
  input  logic [4:0]       ret_rs2_addr_i,
  input  logic [4:0]       ret_rd_addr_i,
  input  logic [31:0]      ret_rs1_rdata_i,
  input  logic [31:0]      ret_rs2_rdata_i,
  input  logic [31:0]      ret_rd_wdata_i,
  input  logic [31:0]      ret_pc_rdata_i,
  input  logic [31:0]      ret_pc_wdata_i,
  input  logic [31:0]      ret_mem_addr_i,
  input  logic [31:0]      ret_mem_rdata_i,
  input  logic [31:0]      ret_mem_wdata_i,
  input  logic [3:0]       ret_mem_rmask_i,
  input  logic [3:0]       ret_mem_wmask_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_order_o,
  output logic [31:0]      out_insn_o,
  output logic             out_trap_o,
  output logic             out_halt_o,
  output logic             out_intr_o,
  output logic [1:0]       out_mode_o,
  output logic [1:0]       out_ixl_o,
  output logic [4:0]       out_rs1_addr_o,
  output logic [4:0]       out_rs2_addr_o,
  output logic [4:0]       out_rd_addr_o,
  output logic [31:0]      out_rs1_rdata_o,
  output logic [31:0]      out_rs2_rdata_o,
  output logic [31:0]      out_rd_wdata_o,
  output logic [31:0]      out_pc_rdata_o,
  output logic [31:0]      out_pc_wdata_o,
  output logic [31:0]      out_mem_addr_o,
  output logic [31:0]      out_mem_rdata_o,
  output logic [31:0]      out_mem_wdata_o,
  output logic [3:0]       out_mem_rmask_o,
  output logic [3:0]       out_mem_wmask_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             overflow_o,
  output logic             halted_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } rec_t;

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [AW:0]      wr_ptr, rd_ptr;
  rec_t             mem [DEPTH];
  rec_t             wr_rec, head;
  logic [63:0]      order_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             ovf_q;
  logic             empty, full, capture, pop, push, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign capture = (state == RUN) && ret_valid_i;
  assign pop     = !empty && out_ready_i;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    wr_rec           = '0;
    wr_rec.order     = order_q;
    wr_rec.insn      = ret_insn_i;
    wr_rec.trap      = ret_trap_i;
    wr_rec.halt      = ret_halt_i;
    wr_rec.intr      = ret_intr_i;
    wr_rec.mode      = ret_mode_i;
    wr_rec.rs1_addr  = ret_rs1_addr_i;
    wr_rec.rs2_addr  = ret_rs2_addr_i;
    wr_rec.rd_addr   = ret_rd_addr_i;
    wr_rec.rs1_rdata = ret_rs1_rdata_i;
    wr_rec.rs2_rdata = ret_rs2_rdata_i;
    wr_rec.rd_wdata  = (ret_rd_addr_i == '0) ? '0 : ret_rd_wdata_i;
    wr_rec.pc_rdata  = ret_pc_rdata_i;
    wr_rec.pc_wdata  = ret_pc_wdata_i;
    wr_rec.mem_addr  = (ret_mem_rmask_i == '0 && ret_mem_wmask_i == '0) ? '0 : ret_mem_addr_i;
    wr_rec.mem_rdata = (ret_mem_rmask_i == '0) ? '0 : ret_mem_rdata_i;
    wr_rec.mem_wdata = (ret_mem_wmask_i == '0) ? '0 : ret_mem_wdata_i;
    wr_rec.mem_rmask = ret_mem_rmask_i;
    wr_rec.mem_wmask = ret_mem_wmask_i;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      order_q    <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push)    wr_ptr  <= wr_ptr + 1'b1;
      if (pop)     rd_ptr  <= rd_ptr + 1'b1;
      if (capture) order_q <= order_q + 64'd1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register / next-state / outputs.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && capture && ret_halt_i) state_nxt = HALTED;
  end

  always_comb begin
    halted_o = (state == HALTED);
  end

  assign head        = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign out_valid_o = !empty;
  assign drop_cnt_o  = drop_cnt_q;
  assign overflow_o  = ovf_q;
  assign out_ixl_o   = 2'd1;

  assign out_order_o     = head.order;
  assign out_insn_o      = head.insn;
  assign out_trap_o      = head.trap;
  assign out_halt_o      = head.halt;
  assign out_intr_o      = head.intr;
  assign out_mode_o      = head.mode;
  assign out_rs1_addr_o  = head.rs1_addr;
  assign out_rs2_addr_o  = head.rs2_addr;
  assign out_rd_addr_o   = head.rd_addr;
  assign out_rs1_rdata_o = head.rs1_rdata;
  assign out_rs2_rdata_o = head.rs2_rdata;
  assign out_rd_wdata_o  = head.rd_wdata;
  assign out_pc_rdata_o  = head.pc_rdata;
  assign out_pc_wdata_o  = head.pc_wdata;
  assign out_mem_addr_o  = head.mem_addr;
  assign out_mem_rdata_o = head.mem_rdata;
  assign out_mem_wdata_o = head.mem_wdata;
  assign out_mem_rmask_o = head.mem_rmask;
  assign out_mem_wmask_o = head.mem_wmask;
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: directed scenarios plus random traffic against a
// queue-based model of the trace buffer.
module tb_rvfi_trace_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap, halt, intr;
    logic [1:0]  mode;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1d, rs2d, rdw, pcr, pcw, maddr, mrd, mwd;
    logic [3:0]  rmask, wmask;
  } tr_t;

  logic clk = 0, reset = 0;
  logic ret_valid_i = 0, ret_trap_i = 0, ret_halt_i = 0, ret_intr_i = 0;
  logic [31:0] ret_insn_i = 0;
  logic [1:0]  ret_mode_i = 0;
  logic [4:0]  ret_rs1_addr_i = 0, ret_rs2_addr_i = 0, ret_rd_addr_i = 0;
  logic [31:0] ret_rs1_rdata_i = 0, ret_rs2_rdata_i = 0, ret_rd_wdata_i = 0;
  logic [31:0] ret_pc_rdata_i = 0, ret_pc_wdata_i = 0;
  logic [31:0] ret_mem_addr_i = 0, ret_mem_rdata_i = 0, ret_mem_wdata_i = 0;
  logic [3:0]  ret_mem_rmask_i = 0, ret_mem_wmask_i = 0;
  logic        out_ready_i = 0;
  logic        out_valid_o, out_trap_o, out_halt_o, out_intr_o, overflow_o, halted_o;
  logic [63:0] out_order_o;
  logic [31:0] out_insn_o, out_rs1_rdata_o, out_rs2_rdata_o, out_rd_wdata_o;
  logic [31:0] out_pc_rdata_o, out_pc_wdata_o, out_mem_addr_o, out_mem_rdata_o, out_mem_wdata_o;
  logic [1:0]  out_mode_o, out_ixl_o;
  logic [4:0]  out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o;
  logic [3:0]  out_mem_rmask_o, out_mem_wmask_o;
  logic [CNT_W-1:0] drop_cnt_o;

  int total = 0, bad = 0;

  // Model state
  tr_t         mq[$];
  logic [63:0] m_order = 0;
  logic [CNT_W-1:0] m_drop = 0;
  bit          m_ovf = 0, m_halt = 0;

  rvfi_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ret_valid_i(ret_valid_i), .ret_insn_i(ret_insn_i),
    .ret_trap_i(ret_trap_i), .ret_halt_i(ret_halt_i), .ret_intr_i(ret_intr_i),
    .ret_mode_i(ret_mode_i), .ret_rs1_addr_i(ret_rs1_addr_i), .ret_rs2_addr_i(ret_rs2_addr_i),
    .ret_rd_addr_i(ret_rd_addr_i), .ret_rs1_rdata_i(ret_rs1_rdata_i),
    .ret_rs2_rdata_i(ret_rs2_rdata_i), .ret_rd_wdata_i(ret_rd_wdata_i),
    .ret_pc_rdata_i(ret_pc_rdata_i), .ret_pc_wdata_i(ret_pc_wdata_i),
    .ret_mem_addr_i(ret_mem_addr_i), .ret_mem_rdata_i(ret_mem_rdata_i),
    .ret_mem_wdata_i(ret_mem_wdata_i), .ret_mem_rmask_i(ret_mem_rmask_i),
    .ret_mem_wmask_i(ret_mem_wmask_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_order_o(out_order_o), .out_insn_o(out_insn_o), .out_trap_o(out_trap_o),
    .out_halt_o(out_halt_o), .out_intr_o(out_intr_o), .out_mode_o(out_mode_o),
    .out_ixl_o(out_ixl_o), .out_rs1_addr_o(out_rs1_addr_o), .out_rs2_addr_o(out_rs2_addr_o),
    .out_rd_addr_o(out_rd_addr_o), .out_rs1_rdata_o(out_rs1_rdata_o),
    .out_rs2_rdata_o(out_rs2_rdata_o), .out_rd_wdata_o(out_rd_wdata_o),
    .out_pc_rdata_o(out_pc_rdata_o), .out_pc_wdata_o(out_pc_wdata_o),
    .out_mem_addr_o(out_mem_addr_o), .out_mem_rdata_o(out_mem_rdata_o),
    .out_mem_wdata_o(out_mem_wdata_o), .out_mem_rmask_o(out_mem_rmask_o),
    .out_mem_wmask_o(out_mem_wmask_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  function automatic tr_t raw_in();
    tr_t r;
    r = '{order: 64'd0, insn: ret_insn_i, trap: ret_trap_i, halt: ret_halt_i, intr: ret_intr_i,
          mode: ret_mode_i, rs1a: ret_rs1_addr_i, rs2a: ret_rs2_addr_i, rda: ret_rd_addr_i,
          rs1d: ret_rs1_rdata_i, rs2d: ret_rs2_rdata_i, rdw: ret_rd_wdata_i,
          pcr: ret_pc_rdata_i, pcw: ret_pc_wdata_i, maddr: ret_mem_addr_i,
          mrd: ret_mem_rdata_i, mwd: ret_mem_wdata_i, rmask: ret_mem_rmask_i,
          wmask: ret_mem_wmask_i};
    return r;
  endfunction

  // RVFI rules: fields without a meaningful access read as zero.
  function automatic tr_t norm(tr_t r);
    if (r.rda == 0) r.rdw = 0;
    if (r.rmask == 0) r.mrd = 0;
    if (r.wmask == 0) r.mwd = 0;
    if (r.rmask == 0 && r.wmask == 0) r.maddr = 0;
    return r;
  endfunction

  function automatic tr_t dut_head();
    tr_t r;
    r = '{order: out_order_o, insn: out_insn_o, trap: out_trap_o, halt: out_halt_o,
          intr: out_intr_o, mode: out_mode_o, rs1a: out_rs1_addr_o, rs2a: out_rs2_addr_o,
          rda: out_rd_addr_o, rs1d: out_rs1_rdata_o, rs2d: out_rs2_rdata_o,
          rdw: out_rd_wdata_o, pcr: out_pc_rdata_o, pcw: out_pc_wdata_o,
          maddr: out_mem_addr_o, mrd: out_mem_rdata_o, mwd: out_mem_wdata_o,
          rmask: out_mem_rmask_o, wmask: out_mem_wmask_o};
    return r;
  endfunction

  function automatic tr_t exp_head();
    tr_t z;
    z = '0;
    return (mq.size() != 0) ? mq[0] : z;
  endfunction

  task automatic drive(input bit v, input bit h);
    ret_valid_i     = v;
    ret_halt_i      = h;
    ret_insn_i      = $urandom;
    ret_trap_i      = 1'($urandom);
    ret_intr_i      = 1'($urandom);
    ret_mode_i      = 2'($urandom);
    ret_rs1_addr_i  = 5'($urandom);
    ret_rs2_addr_i  = 5'($urandom);
    ret_rd_addr_i   = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
    ret_rs1_rdata_i = $urandom;
    ret_rs2_rdata_i = $urandom;
    ret_rd_wdata_i  = $urandom;
    ret_pc_rdata_i  = $urandom;
    ret_pc_wdata_i  = $urandom;
    ret_mem_addr_i  = $urandom;
    ret_mem_rdata_i = $urandom;
    ret_mem_wdata_i = $urandom;
    ret_mem_rmask_i = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
    ret_mem_wmask_i = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
  endtask

  // One clock: the model observes the same inputs the DUT samples at this edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_order = 0; m_drop = 0; m_ovf = 0; m_halt = 0;
    end else begin
      int  sz;
      bit  pop;
      tr_t r;
      sz  = mq.size();
      pop = (sz > 0) && out_ready_i;
      if (pop) void'(mq.pop_front());
      if (!m_halt && ret_valid_i) begin
        r = norm(raw_in());
        r.order = m_order;
        m_order = m_order + 1;
        if (sz < DEPTH || pop) mq.push_back(r);
        else begin
          m_ovf = 1;
          if (m_drop != {CNT_W{1'b1}}) m_drop = m_drop + 1;
        end
        if (ret_halt_i) m_halt = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; drive(0, 0); cycle(); reset = 0;
  endtask

  task automatic test_reset();
    out_ready_i = 0;
    reset = 1; drive(1, 0); cycle(); cycle(); reset = 0; drive(0, 0);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", out_valid_o); end
    total++; if (drop_cnt_o !== '0 || overflow_o !== 1'b0 || halted_o !== 1'b0) begin
      bad++; $display("FAIL reset_status: drop=%0d ovf=%b halt=%b exp 0/0/0", drop_cnt_o, overflow_o, halted_o); end
    total++; if (dut_head() !== '0) begin bad++; $display("FAIL reset_data: got %h exp 0", dut_head()); end
    total++; if (out_ixl_o !== 2'd1) begin bad++; $display("FAIL ixl: got %0d exp 1", out_ixl_o); end
  endtask

  task automatic test_back_to_back();
    do_reset(); out_ready_i = 1;
    for (int j = 0; j < 3; j++) begin
      drive(1, 0); cycle();
      total++; if (out_valid_o !== 1'b1 || out_order_o !== 64'(j)) begin
        bad++; $display("FAIL b2b_%0d: valid=%b order=%0d exp 1/%0d", j, out_valid_o, out_order_o, j); end
      total++; if (dut_head() !== exp_head()) begin
        bad++; $display("FAIL b2b_rec_%0d: got %h exp %h", j, dut_head(), exp_head()); end
    end
    drive(0, 0); cycle();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b exp 0", out_valid_o); end
  endtask

  task automatic test_normalise();
    do_reset(); out_ready_i = 1;
    drive(1, 0);
    ret_rd_addr_i = 0; ret_rd_wdata_i = 32'hDEADBEEF; ret_mem_rmask_i = 0;
    ret_mem_rdata_i = 32'h1234; ret_mem_wmask_i = 0;
    cycle();
    total++; if (out_rd_wdata_o !== 0 || out_mem_rdata_o !== 0 || out_mem_addr_o !== 0 || out_mem_wdata_o !== 0) begin
      bad++; $display("FAIL norm_zero: rdw=%h mrd=%h maddr=%h mwd=%h exp 0", out_rd_wdata_o, out_mem_rdata_o, out_mem_addr_o, out_mem_wdata_o); end
    for (int j = 0; j < 4; j++) begin
      drive(1, 0);
      ret_rd_addr_i = 5'(j * 7); ret_mem_rmask_i = (j & 1) ? 4'hF : 4'h0; ret_mem_wmask_i = (j & 2) ? 4'h3 : 4'h0;
      cycle();
      total++; if (dut_head() !== exp_head()) begin
        bad++; $display("FAIL norm_%0d: got %h exp %h", j, dut_head(), exp_head()); end
    end
  endtask

  task automatic test_overflow();
    do_reset(); out_ready_i = 0;
    for (int j = 0; j < 10; j++) begin drive(1, 0); cycle(); end
    total++; if (drop_cnt_o !== 16'd2 || overflow_o !== 1'b1) begin
      bad++; $display("FAIL ovf_cnt: drop=%0d ovf=%b exp 2/1", drop_cnt_o, overflow_o); end
    drive(0, 0); out_ready_i = 1;
    for (int j = 0; j < 8; j++) begin
      total++; if (out_valid_o !== 1'b1 || out_order_o !== 64'(j)) begin
        bad++; $display("FAIL ovf_drain_%0d: valid=%b order=%0d exp 1/%0d", j, out_valid_o, out_order_o, j); end
      cycle();
    end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b exp 0", out_valid_o); end
    drive(1, 0); cycle();
    total++; if (out_order_o !== 64'd10) begin bad++; $display("FAIL ovf_next_order: got %0d exp 10", out_order_o); end
  endtask

  task automatic test_full_pop();
    int n;
    logic [63:0] last;
    do_reset(); out_ready_i = 0;
    for (int j = 0; j < DEPTH; j++) begin drive(1, 0); cycle(); end
    out_ready_i = 1; drive(1, 0); cycle();
    total++; if (drop_cnt_o !== '0 || overflow_o !== 1'b0 || out_order_o !== 64'd1) begin
      bad++; $display("FAIL fullpop: drop=%0d ovf=%b head=%0d exp 0/0/1", drop_cnt_o, overflow_o, out_order_o); end
    drive(0, 0); n = 0; last = '1;
    while (out_valid_o === 1'b1 && n < 20) begin
      total++; if (dut_head() !== exp_head()) begin
        bad++; $display("FAIL fullpop_rec_%0d: got %h exp %h", n, dut_head(), exp_head()); end
      last = out_order_o; cycle(); n++;
    end
    total++; if (n != DEPTH || last !== 64'd8) begin
      bad++; $display("FAIL fullpop_drain: count=%0d last=%0d exp 8/8", n, last); end
  endtask

  task automatic test_halt();
    int n;
    logic [63:0] last;
    do_reset(); out_ready_i = 0;
    for (int j = 0; j < 5; j++) begin drive(1, 0); cycle(); end
    drive(1, 1); cycle();
    total++; if (halted_o !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b exp 1", halted_o); end
    for (int j = 0; j < 4; j++) begin drive(1, 0); cycle(); end
    total++; if (drop_cnt_o !== '0 || halted_o !== 1'b1) begin
      bad++; $display("FAIL halt_ignore: drop=%0d halt=%b exp 0/1", drop_cnt_o, halted_o); end
    drive(0, 0); out_ready_i = 1; n = 0; last = '1;
    while (out_valid_o === 1'b1 && n < 20) begin last = out_order_o; cycle(); n++; end
    total++; if (n != 6 || last !== 64'd5) begin
      bad++; $display("FAIL halt_drain: count=%0d last=%0d exp 6/5", n, last); end
  endtask

  task automatic test_reset_midstream();
    do_reset(); out_ready_i = 0;
    for (int j = 0; j < 4; j++) begin drive(1, 0); cycle(); end
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL mid_prefill: got %b exp 1", out_valid_o); end
    reset = 1; drive(1, 0); cycle(); reset = 0;
    total++; if (out_valid_o !== 1'b0 || dut_head() !== '0) begin
      bad++; $display("FAIL mid_reset: valid=%b head=%h exp 0", out_valid_o, dut_head()); end
    drive(1, 0); cycle();
    total++; if (out_valid_o !== 1'b1 || out_order_o !== 64'd0) begin
      bad++; $display("FAIL mid_order: valid=%b order=%0d exp 1/0", out_valid_o, out_order_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 4 != 0, i == 350);
      out_ready_i = ((i / 50) % 2) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      cycle();
      total++; if (out_valid_o !== (mq.size() != 0) || dut_head() !== exp_head()) begin
        bad++; $display("FAIL rand_head_%0d: valid=%b got %h exp %h", i, out_valid_o, dut_head(), exp_head()); end
      total++; if (drop_cnt_o !== m_drop || overflow_o !== m_ovf || halted_o !== m_halt) begin
        bad++; $display("FAIL rand_status_%0d: drop=%0d ovf=%b halt=%b exp %0d/%b/%b", i, drop_cnt_o, overflow_o, halted_o, m_drop, m_ovf, m_halt); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_normalise();
    test_overflow();
    test_full_pop();
    test_halt();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, exp finish before 500000");
    $fatal(1);
  end
endmodule
